// File: rtl/control_74hc165d.sv
// Scan controller for a daisy-chained 74HC165 chain: load, clock WIDTH bits out, present one word.
// Optional CONTROL_74HC165D_DEBOUNCE_EN: publish a word only when two consecutive raw scans agree.
module control_74hc165d #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             s_clk,
  input  logic             s_reset,
  input  logic             start,
  input  logic             serial_in,
  output logic             load_n,
  output logic             data_clock,
  output logic             busy,
  output logic             data_valid,
  output logic [WIDTH-1:0] data_word
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [BIT_W-1:0] bitn_reg, bitn_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic             capture;
  logic             accept;

  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bitn_reg  <= '0;
      sr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bitn_reg  <= bitn_next;
      sr_reg    <= sr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bitn_next  = bitn_reg;
    sr_next    = sr_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          div_next   = DIV_MAX;
          bitn_next  = '0;
        end
      end
      LOAD: begin
        if (div_reg == '0) begin
          state_next = SHIFT_LO;
          div_next   = DIV_MAX;
        end else begin
          div_next = div_reg - 1'b1;
        end
      end
      SHIFT_LO: begin
        // Sample just before data_clock rises, so the chain's Q7 is still stable.
        if (div_reg == '0) begin
          sr_next    = {sr_reg[WIDTH-2:0], serial_in};
          state_next = SHIFT_HI;
          div_next   = DIV_MAX;
        end else begin
          div_next = div_reg - 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_reg == '0) begin
          if (bitn_reg == BIT_LAST) begin
            capture    = 1'b1;
            state_next = IDLE;
            div_next   = '0;
            bitn_next  = '0;
          end else begin
            bitn_next  = bitn_reg + 1'b1;
            state_next = SHIFT_LO;
            div_next   = DIV_MAX;
          end
        end else begin
          div_next = div_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CONTROL_74HC165D_DEBOUNCE_EN
  logic [WIDTH-1:0] raw_reg;

  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) begin
      raw_reg <= '0;
    end else if (capture) begin
      raw_reg <= sr_reg;
    end
  end

  assign accept = capture && (sr_reg == raw_reg);
`else
  assign accept = capture;
`endif

  // Outputs are decoded from the next state so every pin is a plain flop.
  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) begin
      load_n     <= 1'b1;
      data_clock <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_word  <= '0;
    end else begin
      load_n     <= (state_next != LOAD);
      data_clock <= (state_next == SHIFT_HI);
      busy       <= (state_next != IDLE);
      data_valid <= accept;
      if (accept) begin
        data_word <= sr_reg;
      end
    end
  end

endmodule

// File: doc/control_74hc165d.md
# control_74hc165d

Serial key/input reader for a daisy-chained 74HC165 parallel-in/serial-out shift-register chain. It is the read-side counterpart of the 74HC595 display driver. On each scan request it pulses the chain's parallel-load line, clocks WIDTH bits out of the chain, and presents them as one parallel word with a single-cycle valid strobe. It sits between the board's key matrix and the calculator's key-decode logic.

## Interface

**Parameters**
- `WIDTH`, default 16: number of bits in the chain (8 per 74HC165); must be at least 2.
- `CLK_DIV`, default 4: s_clk cycles per half-period of `data_clock` and per `load_n` low pulse; must be at least 1.

**Ports**
- `s_clk` input 1: system clock; all state changes on its rising edge.
- `s_reset` input 1: asynchronous, active-low reset.
- `start` input 1: scan request, sampled only in IDLE.
- `serial_in` input 1: chain serial output (Q7 of the last 74HC165).
- `load_n` output 1: chain PL; low means parallel load.
- `data_clock` output 1: chain CP; the chain shifts on its rising edge.
- `busy` output 1: high while a scan is in progress.
- `data_valid` output 1: one-cycle strobe when `data_word` updates.
- `data_word` output WIDTH: last accepted scan, MSB = first bit shifted out.

## Operation

**States:** IDLE, LOAD, SHIFT_LO, SHIFT_HI. A single down-counter `div` and a bit counter `bitn` drive all transitions.

- **IDLE:** `load_n`=1, `data_clock`=0, `busy`=0.
  - `start`=1 at an edge → LOAD.
- **LOAD:** `load_n`=0 and `busy`=1 for CLK_DIV cycles, then → SHIFT_LO.
- **SHIFT_LO:** `load_n`=1, `data_clock`=0 for CLK_DIV cycles.
  - On the edge that ends the phase, `serial_in` shifts into the LSB of an internal shift register, which shifts left.
  - → SHIFT_HI.
- **SHIFT_HI:** `data_clock`=1 for CLK_DIV cycles.
  - If `bitn` < WIDTH-1: increment `bitn` and go → SHIFT_LO.
  - Otherwise, on the ending edge: capture the shift register into `data_word`, assert `data_valid`, go → IDLE.
- The first sampled bit lands in `data_word[WIDTH-1]`.
- Exactly WIDTH rising `data_clock` edges occur per scan. The final edge is harmless.
- `start` during LOAD, SHIFT_LO or SHIFT_HI is ignored; it is not queued.
- `data_word` holds its value between scans. It changes only together with `data_valid`.

**Reset**
- Asserting `s_reset` low forces, asynchronously: IDLE, `load_n`=1, `data_clock`=0, `busy`=0, `data_valid`=0, `data_word`=0, counters=0.
- A scan in progress at reset is aborted and discarded.

## Timing

Let E0 be the edge at which `start`=1 is sampled in IDLE.

- `load_n` falls at E0 and rises at E0+CLK_DIV.
- Bit i (0-based) is sampled, and `data_clock` rises, at E0 + CLK_DIV·(2i+2).
- `data_clock` falls at E0 + CLK_DIV·(2i+3).
- `data_valid` and the new `data_word` appear at E0 + CLK_DIV·(2·WIDTH+1); with the defaults that is E0+132.
- `data_valid` drops at the following edge.
- `busy` rises at E0 and falls at the `data_valid` edge.
- With `start` held high, the next E0 is the edge after `data_valid`. Scan period is CLK_DIV·(2·WIDTH+1)+1 cycles (133 with defaults).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

`CONTROL_74HC165D_DEBOUNCE_EN`

- **Defined:**
  - Each completed scan's raw word is compared with the previous raw word, held in a WIDTH-bit register that resets to 0.
  - If they are equal, `data_word` updates and `data_valid` pulses at the normal edge.
  - If they differ, neither changes. The raw register is updated in both cases.
  - `busy` and scan timing are unchanged.
- **Undefined:** every completed scan updates `data_word` and pulses `data_valid`. The raw register is not synthesized.

## Test plan

All scenarios use a behavioural 74HC165 chain model on the outputs and default parameters unless noted.

1. **Reset values:** hold `s_reset`=0 while `start`=1 → `load_n`=1, `data_clock`=0, `busy`=0, `data_valid`=0, `data_word`=16'h0000.
2. **Single scan:** chain holds 16'hA5C3, one-cycle `start` at E0 →
   - `load_n` low for 4 cycles;
   - exactly 16 `data_clock` rising edges, period 8;
   - `data_valid` high only at E0+132, `data_word`=16'hA5C3.
3. **Start ignored while busy:** `start` pulsed again at E0+10 and E0+100 → exactly one `data_valid` pulse and no second `load_n` pulse.
4. **Continuous scanning:** `start` held high, chain 16'h1234 then 16'h5678 after the first load →
   - `data_valid` pulses 133 cycles apart;
   - `data_word` reads 16'h1234, then 16'h5678.
5. **Reset mid-scan:** `s_reset` asserted at E0+70 →
   - outputs take reset values before the next edge;
   - no `data_valid`;
   - a later scan of 16'hFFFF returns 16'hFFFF.
6. **Debounce** (`CONTROL_74HC165D_DEBOUNCE_EN` defined): consecutive scans of 16'h1234, 16'h1235, 16'h1235 → no `data_valid` on scans 1–2; pulse on scan 3 with `data_word`=16'h1235.
